// File: rtl/ecc_apb_regfile.sv
// ecc_apb_regfile: APB3 register front-end driving operands and a start pulse to the ECC core.
// Define ECC_REGFILE_TIMEOUT_EN to add a BUSY watchdog of TIMEOUT_CYCLES cycles.
module ecc_apb_regfile #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [AMBA_ADDR_WIDTH-1:0] paddr,
    input  logic [AMBA_WORD-1:0]       pwdata,
    output logic [AMBA_WORD-1:0]       prdata,
    output logic [1:0]                 ctrl,
    output logic [DATA_WIDTH-1:0]      data_in,
    output logic [1:0]                 codeword_width,
    output logic [AMBA_WORD-1:0]       noise,
    output logic                       start,
    input  logic                       operation_done
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [AMBA_ADDR_WIDTH-1:0] A_CTRL   = 'h0;
    localparam logic [AMBA_ADDR_WIDTH-1:0] A_DATA   = 'h4;
    localparam logic [AMBA_ADDR_WIDTH-1:0] A_CW     = 'h8;
    localparam logic [AMBA_ADDR_WIDTH-1:0] A_NOISE  = 'hC;
    localparam logic [AMBA_ADDR_WIDTH-1:0] A_STATUS = 'h10;

    state_t               state;
    logic                 done_f, drop_f, ill_f, to_f;
    logic                 wr, rd, rd_access, op_wr, timeout_hit;
    logic [AMBA_WORD-1:0] rdata;

    always_comb begin
        wr        = psel & penable & pwrite;
        rd        = psel & ~penable & ~pwrite;
        rd_access = psel & penable & ~pwrite;
        op_wr     = wr & ((paddr == A_CTRL) | (paddr == A_DATA) | (paddr == A_CW) | (paddr == A_NOISE));
        rdata     = paddr == A_CTRL   ? AMBA_WORD'(ctrl) :
                    paddr == A_DATA   ? AMBA_WORD'(data_in) :
                    paddr == A_CW     ? AMBA_WORD'(codeword_width) :
                    paddr == A_NOISE  ? noise :
                    paddr == A_STATUS ? AMBA_WORD'({to_f, ill_f, drop_f, done_f, state == BUSY}) : '0;
    end

`ifdef ECC_REGFILE_TIMEOUT_EN
    localparam int             CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TLAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt;
    // Held at zero in IDLE so it is zero on every entry to BUSY.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) cnt <= '0;
        else cnt <= cnt + CW'(1);
    end
    assign timeout_hit = (state == BUSY) && (cnt == TLAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            start          <= 1'b0;
            ctrl           <= '0;
            data_in        <= '0;
            codeword_width <= '0;
            noise          <= '0;
            prdata         <= '0;
            {to_f, ill_f, drop_f, done_f} <= '0;
        end else begin
            start  <= 1'b0;
            prdata <= rd ? rdata : rd_access ? prdata : '0;
            // Clear first so any sticky set below in the same cycle wins.
            if (wr && paddr == A_STATUS) {to_f, ill_f, drop_f, done_f} <= '0;
            if (state == IDLE) begin
                if (wr && paddr == A_CTRL) begin
                    ctrl <= pwdata[1:0];
                    if (&pwdata[1:0]) ill_f <= 1'b1;
                    else begin
                        start <= 1'b1;
                        state <= BUSY;
                    end
                end
                if (wr && paddr == A_DATA)  data_in        <= pwdata[DATA_WIDTH-1:0];
                if (wr && paddr == A_CW)    codeword_width <= pwdata[1:0];
                if (wr && paddr == A_NOISE) noise          <= pwdata;
            end else begin
                if (op_wr) drop_f <= 1'b1;
                if (operation_done) begin
                    state  <= IDLE;
                    done_f <= 1'b1;
                end else if (timeout_hit) begin
                    state <= IDLE;
                    to_f  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ecc_apb_regfile.sv
// tb_ecc_apb_regfile: directed plus randomized APB traffic checked every cycle against a behavioural model.
module tb_ecc_apb_regfile;
    localparam int TO = 8;

    logic        clk = 0, rst = 1, psel = 0, penable = 0, pwrite = 0, operation_done = 0;
    logic [31:0] paddr = 0, pwdata = 0;
    logic [31:0] prdata, data_in, noise;
    logic [1:0]  ctrl, codeword_width;
    logic        start;

    int n_chk = 0, n_fail = 0;
    bit check_en = 0, rand_done = 0;

    logic [1:0]  m_ctrl, m_cw;
    logic [31:0] m_data, m_noise, m_prdata;
    bit          m_busy, m_done, m_drop, m_ill, m_to, m_start;
    int          m_cnt;

    always #5 clk = ~clk;

    ecc_apb_regfile #(.DATA_WIDTH(32), .AMBA_WORD(32), .AMBA_ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .ctrl(ctrl), .data_in(data_in),
        .codeword_width(codeword_width), .noise(noise), .start(start), .operation_done(operation_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a)
            32'h0:   return {30'd0, m_ctrl};
            32'h4:   return m_data;
            32'h8:   return {30'd0, m_cw};
            32'hC:   return m_noise;
            32'h10:  return {27'd0, m_to, m_ill, m_drop, m_done, m_busy};
            default: return 32'd0;
        endcase
    endfunction

    // Reference behaviour applied once per rising edge from the inputs held across it.
    task automatic model_step();
        logic [31:0] nx;
        bit wr;
        if (rst) begin
            m_ctrl = 0; m_cw = 0; m_data = 0; m_noise = 0; m_prdata = 0;
            m_busy = 0; m_done = 0; m_drop = 0; m_ill = 0; m_to = 0; m_start = 0; m_cnt = 0;
            return;
        end
        wr = psel && penable && pwrite;
        nx = (psel && !penable && !pwrite) ? m_read(paddr) : (psel && penable && !pwrite) ? m_prdata : 32'd0;
        m_start = 0;
        if (wr && paddr == 32'h10) begin
            m_done = 0; m_drop = 0; m_ill = 0; m_to = 0;
        end
        if (!m_busy) begin
            if (wr && paddr == 32'h0) begin
                m_ctrl = pwdata[1:0];
                if (pwdata[1:0] == 2'd3) m_ill = 1;
                else begin
                    m_start = 1; m_busy = 1; m_cnt = 0;
                end
            end
            if (wr && paddr == 32'h4) m_data = pwdata;
            if (wr && paddr == 32'h8) m_cw = pwdata[1:0];
            if (wr && paddr == 32'hC) m_noise = pwdata;
        end else begin
            if (wr && paddr inside {32'h0, 32'h4, 32'h8, 32'hC}) m_drop = 1;
            m_cnt++;
            if (operation_done) begin
                m_busy = 0; m_done = 1;
            end
`ifdef ECC_REGFILE_TIMEOUT_EN
            else if (m_cnt == TO) begin
                m_busy = 0; m_to = 1;
            end
`endif
        end
        m_prdata = nx;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("prdata", prdata, m_prdata);
            chk("ctrl", {30'd0, ctrl}, {30'd0, m_ctrl});
            chk("data_in", data_in, m_data);
            chk("codeword_width", {30'd0, codeword_width}, {30'd0, m_cw});
            chk("noise", noise, m_noise);
            chk("start", {31'd0, start}, {31'd0, m_start});
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        operation_done = rand_done && ($urandom_range(0, 5) == 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        tick();
        penable = 1;
        tick();
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        tick();
        d = prdata;
        penable = 1;
        tick();
        psel = 0; penable = 0;
    endtask

    task automatic pulse_done();
        operation_done = 1;
        tick();
    endtask

    logic [31:0] rv;
    logic [31:0] addrs [7] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h2};

    initial begin
        ticks(2);
        rst = 0;
        check_en = 1;
        chk("reset_start", {31'd0, start}, 0);
        for (int i = 0; i < 5; i++) begin
            apb_read(addrs[i], rv);
            chk("reset_read", rv, 0);
        end

        apb_write(32'h4, 32'hA5A5_1234);
        apb_write(32'h8, 32'h2);
        apb_write(32'hC, 32'h0000_0010);
        apb_write(32'h0, 32'h1);
        chk("start_after_ctrl", {31'd0, start}, 1);
        tick();
        chk("start_one_cycle", {31'd0, start}, 0);
        chk("op_data_in", data_in, 32'hA5A5_1234);
        chk("op_cw", {30'd0, codeword_width}, 2);
        chk("op_noise", noise, 32'h10);
        chk("op_ctrl", {30'd0, ctrl}, 1);
        apb_read(32'h10, rv);
        chk("status_busy", rv, 32'h1);

        apb_write(32'h4, 32'hFFFF_FFFF);
        chk("busy_data_kept", data_in, 32'hA5A5_1234);
        pulse_done();
        apb_read(32'h10, rv);
        chk("status_done_drop", rv, 32'h6);
        apb_write(32'h10, 32'h0);
        apb_read(32'h10, rv);
        chk("status_cleared", rv, 32'h0);

        apb_write(32'h0, 32'h3);
        chk("illegal_no_start", {31'd0, start}, 0);
        apb_read(32'h10, rv);
        chk("status_illegal", rv, 32'h8);
        apb_read(32'h0, rv);
        chk("ctrl_reads_3", rv, 32'h3);
        apb_write(32'h0, 32'h0);
        chk("start_ctrl0", {31'd0, start}, 1);

        rst = 1;
        tick();
        rst = 0;
        chk("rst_start", {31'd0, start}, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_noise", noise, 0);
        chk("rst_ctrl", {30'd0, ctrl}, 0);
        apb_read(32'h10, rv);
        chk("rst_status", rv, 0);
        apb_write(32'h0, 32'h2);
        chk("start_ctrl2", {31'd0, start}, 1);
        pulse_done();
        apb_read(32'h10, rv);
        chk("status_done", rv, 32'h2);
        apb_write(32'h10, 32'h0);

`ifdef ECC_REGFILE_TIMEOUT_EN
        apb_write(32'h0, 32'h0);
        ticks(6);
        apb_read(32'h10, rv);
        chk("to_still_busy", rv, 32'h1);
        apb_read(32'h10, rv);
        chk("to_status", rv, 32'h10);
        apb_write(32'h0, 32'h1);
        chk("to_restart", {31'd0, start}, 1);
        pulse_done();
`else
        apb_write(32'h0, 32'h0);
        ticks(100);
        apb_read(32'h10, rv);
        chk("no_timeout_busy", rv, 32'h1);
        pulse_done();
        apb_read(32'h10, rv);
        chk("no_timeout_done", rv, 32'h2);
`endif
        apb_write(32'h10, 32'h0);

        rand_done = 1;
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            a = addrs[$urandom_range(0, 6)];
            if (r < 4) apb_write(a, $urandom);
            else if (r < 8) apb_read(a, rv);
            else ticks($urandom_range(1, 4));
        end
        rand_done = 0;
        ticks(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ecc_apb_regfile.md
Name: ecc_apb_regfile

Overview:
- APB slave front-end directly upstream of the ECC encoder/decoder core.
- Decodes APB3 writes into the CTRL, DATA_IN, CODEWORD_WIDTH and NOISE registers, and drives them to the core as stable operands.
- A CTRL write issues a one-cycle start pulse to the core. The block then tracks the core's operation_done handshake and exposes a STATUS register with busy/done/error bits.

Parameters:
- DATA_WIDTH, 32, width of the data operand driven to the core.
- AMBA_WORD, 32, APB data bus width (pwdata/prdata, NOISE register).
- AMBA_ADDR_WIDTH, 32, APB address width.
- TIMEOUT_CYCLES, 64, watchdog limit in clk cycles; used only when ECC_REGFILE_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  APB direction, 1 = write.
- paddr  in  AMBA_ADDR_WIDTH  APB byte address.
- pwdata  in  AMBA_WORD  APB write data.
- prdata  out  AMBA_WORD  APB read data, registered.
- ctrl  out  2  operation code to core.
- data_in  out  DATA_WIDTH  data operand to core.
- codeword_width  out  2  codeword size code to core.
- noise  out  AMBA_WORD  noise vector to core.
- start  out  1  one-cycle pulse launching a core operation.
- operation_done  in  1  one-cycle pulse from core, operation complete.

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: all outputs 0. FSM is IDLE. All STATUS sticky bits are 0.
- Address map (full-width compare):
  - 0x0 CTRL: bits [1:0], R/W.
  - 0x4 DATA_IN: bits [DATA_WIDTH-1:0], R/W.
  - 0x8 CODEWORD_WIDTH: bits [1:0], R/W.
  - 0xC NOISE: full word, R/W.
  - 0x10 STATUS: read bits [4:0]; any write clears the sticky bits.
  - Unmapped addresses: writes ignored, reads return 0.
- Write acceptance: a write is accepted at the posedge where psel & penable & pwrite. The register updates at that edge. Upper pwdata bits are discarded.
- Read: at the setup-phase edge (psel & ~penable & ~pwrite), prdata is loaded with the addressed value. prdata is held through the access phase and returns to 0 on the edge after the access phase.
- STATUS bits:
  - [0] busy: FSM in BUSY.
  - [1] done: sticky, set by operation_done.
  - [2] wr_drop: sticky, a write was ignored while busy.
  - [3] illegal_ctrl: sticky, a CTRL write of 2'b11.
  - [4] timeout: sticky.
- FSM states: IDLE, BUSY.
- IDLE, accepted CTRL write of 0, 1 or 2:
  - ctrl register updates.
  - start = 1 for exactly the next cycle.
  - FSM goes to BUSY on the same edge that raises start.
- IDLE, CTRL write of 3: ctrl register updates, illegal_ctrl is set, no start, FSM stays IDLE.
- BUSY: writes to CTRL/DATA_IN/CODEWORD_WIDTH/NOISE are dropped and wr_drop is set. STATUS writes still clear sticky bits. Reads work normally.
- BUSY + operation_done: FSM returns to IDLE and done is set on that edge. operation_done in IDLE is ignored.
- Latency:
  - CTRL write edge → start high for cycle N+1.
  - Earliest next accepted CTRL write is the edge after operation_done.
- Simultaneous events:
  - STATUS write and a sticky-set event in the same cycle: set wins.
  - CTRL write in the same cycle as operation_done while BUSY: write is dropped, wr_drop is set, done is set.
- Mid-operation reset: FSM to IDLE; start, operands and STATUS cleared on that edge.
- Operand stability: ctrl/data_in/codeword_width/noise are guaranteed unchanged from start until operation_done.

Optional Feature:
- Macro: ECC_REGFILE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES without operation_done, the FSM returns to IDLE and STATUS[4] is set.
  - If operation_done arrives on the same edge the counter reaches TIMEOUT_CYCLES, done wins and timeout is not set.
- Not defined: no counter is synthesised, STATUS[4] reads 0, and BUSY exits only via operation_done or rst.

Test Plan:
- Reset, then read all five addresses → each returns 0x0; start = 0.
- Write DATA_IN = 0xA5A5_1234, CODEWORD_WIDTH = 2, NOISE = 0x0000_0010, then CTRL = 1 → start high exactly one cycle after the CTRL write edge; outputs equal the written values; STATUS reads 0x1.
- While BUSY, write DATA_IN = 0xFFFF_FFFF → data_in stays 0xA5A5_1234. Pulse operation_done → STATUS reads 0x6. Write STATUS → STATUS reads 0x0.
- In IDLE write CTRL = 3 → no start, STATUS = 0x8, ctrl reads 3. Write CTRL = 0 → start pulses.
- Assert rst while BUSY → next cycle all outputs 0 and STATUS 0. A following CTRL = 2 write starts normally.
- With ECC_REGFILE_TIMEOUT_EN and TIMEOUT_CYCLES = 8, write CTRL = 0 and never pulse operation_done → exactly 8 BUSY cycles, then STATUS = 0x10 and a new CTRL write is accepted.
